// File: rtl/seg_serial_rx_pkg.sv
// -----------------------------------------------------------------------------
// seg_serial_rx_pkg
// Shared definitions for the serial seven-segment link receiver:
//   - receiver FSM state encoding
//   - active-low segment patterns for hex digits 0-F. Bit order is
//     {dp, g, f, e, d, c, b, a}, with dp dark. These values match the
//     encoder in the segment driver.
//   - default frame width (the segment driver word width)
// -----------------------------------------------------------------------------
package seg_serial_rx_pkg;

    localparam int FRAME_W_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OVER  = 2'd2
    } state_e;

    localparam logic [7:0] SEG_HEX_0 = 8'hC0;
    localparam logic [7:0] SEG_HEX_1 = 8'hF9;
    localparam logic [7:0] SEG_HEX_2 = 8'hA4;
    localparam logic [7:0] SEG_HEX_3 = 8'hB0;
    localparam logic [7:0] SEG_HEX_4 = 8'h99;
    localparam logic [7:0] SEG_HEX_5 = 8'h92;
    localparam logic [7:0] SEG_HEX_6 = 8'h82;
    localparam logic [7:0] SEG_HEX_7 = 8'hF8;
    localparam logic [7:0] SEG_HEX_8 = 8'h80;
    localparam logic [7:0] SEG_HEX_9 = 8'h90;
    localparam logic [7:0] SEG_HEX_A = 8'h88;
    localparam logic [7:0] SEG_HEX_B = 8'h83;
    localparam logic [7:0] SEG_HEX_C = 8'hC6;
    localparam logic [7:0] SEG_HEX_D = 8'hA1;
    localparam logic [7:0] SEG_HEX_E = 8'h86;
    localparam logic [7:0] SEG_HEX_F = 8'h8E;

endpackage : seg_serial_rx_pkg

// File: rtl/seg_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg_pattern_decode
// Combinational reverse lookup. It maps one active-low segment byte back to
// the hex nibble that the segment driver encoded.
// Ports:
//   seg_byte_i  [7:0]  segment pattern {dp,g,f,e,d,c,b,a}, active-low
//   nibble_o    [3:0]  decoded hex value (0 for an unknown pattern)
//   ok_o               1 when seg_byte_i is one of the 16 known patterns
// -----------------------------------------------------------------------------
module seg_pattern_decode
    import seg_serial_rx_pkg::*;
(
    input  logic [7:0] seg_byte_i,
    output logic [3:0] nibble_o,
    output logic       ok_o
);

    // Table lookup. Any pattern that is not in the table decodes to 0 with ok_o low.
    always_comb begin
        nibble_o = 4'h0;
        ok_o     = 1'b1;
        case (seg_byte_i)
            SEG_HEX_0: nibble_o = 4'h0;
            SEG_HEX_1: nibble_o = 4'h1;
            SEG_HEX_2: nibble_o = 4'h2;
            SEG_HEX_3: nibble_o = 4'h3;
            SEG_HEX_4: nibble_o = 4'h4;
            SEG_HEX_5: nibble_o = 4'h5;
            SEG_HEX_6: nibble_o = 4'h6;
            SEG_HEX_7: nibble_o = 4'h7;
            SEG_HEX_8: nibble_o = 4'h8;
            SEG_HEX_9: nibble_o = 4'h9;
            SEG_HEX_A: nibble_o = 4'hA;
            SEG_HEX_B: nibble_o = 4'hB;
            SEG_HEX_C: nibble_o = 4'hC;
            SEG_HEX_D: nibble_o = 4'hD;
            SEG_HEX_E: nibble_o = 4'hE;
            SEG_HEX_F: nibble_o = 4'hF;
            default: begin
                nibble_o = 4'h0;
                ok_o     = 1'b0;
            end
        endcase
    end

endmodule : seg_pattern_decode

// File: rtl/seg_serial_rx.sv
// -----------------------------------------------------------------------------
// seg_serial_rx
// Receive end of the serial seven-segment link. Bits arrive MSB-first on
// seg_dt. A bit is present in every cycle where seg_finish is low. When
// seg_finish returns high, the burst ends. A burst of exactly FRAME_W bits
// is a good frame: it is published on frame_data with a one-cycle
// frame_valid pulse. A shorter or longer burst is discarded with a one-cycle
// frame_err pulse.
//
// Optional build macro SEG_SERIAL_RX_DECODE_EN adds the digit_hex and
// digit_ok outputs. They hold the reverse-decoded hex digit for each byte of
// the last good frame.
//
// Ports:
//   clk          system clock (shared with the segment driver)
//   rst          synchronous active-high reset
//   seg_dt       serial data, MSB first
//   seg_finish   0 = bit present this cycle, 1 = idle
//   frame_data   last good frame, bit FRAME_W-1 = first bit received
//   frame_valid  one-cycle pulse, frame_data just updated
//   frame_err    one-cycle pulse, short/over-length burst discarded
//   frame_cnt    good-frame counter, wraps modulo 2^CNT_W
//   busy         high while a burst is in progress
//   digit_hex    (macro only) decoded nibble per byte, byte 0 = bits 7:0
//   digit_ok     (macro only) per-byte known-pattern flag
// -----------------------------------------------------------------------------
module seg_serial_rx
    import seg_serial_rx_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seg_dt,
    input  logic                 seg_finish,
    output logic [FRAME_W-1:0]   frame_data,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic                 busy
`ifdef SEG_SERIAL_RX_DECODE_EN
    ,
    output logic [FRAME_W/2-1:0] digit_hex,
    output logic [FRAME_W/8-1:0] digit_ok
`endif
);

    localparam int                    BITCNT_W = $clog2(FRAME_W + 1);
    localparam logic [BITCNT_W-1:0]   FULL_CNT = BITCNT_W'(FRAME_W);

    state_e                state_q,  state_d;
    logic [FRAME_W-1:0]    shreg_q,  shreg_d;
    logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [FRAME_W-1:0]    frame_data_q;
    logic                  frame_valid_q;
    logic                  frame_err_q;
    logic [CNT_W-1:0]      frame_cnt_q;
    logic                  busy_q;
    logic                  load_s;
    logic                  err_s;

    // Next state, shift/count update, and end-of-burst classification.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        load_s   = 1'b0;
        err_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!seg_finish) begin
                    shreg_d  = {shreg_q[FRAME_W-2:0], seg_dt};
                    bitcnt_d = BITCNT_W'(1);
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!seg_finish) begin
                    if (bitcnt_q < FULL_CNT) begin
                        shreg_d  = {shreg_q[FRAME_W-2:0], seg_dt};
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                    end else begin
                        // The extra bit is dropped. shreg keeps the first
                        // FRAME_W bits, but the burst is already lost.
                        state_d  = ST_OVER;
                    end
                end else begin
                    if (bitcnt_q == FULL_CNT) begin
                        load_s = 1'b1;
                    end else begin
                        err_s  = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_OVER: begin
                if (!seg_finish) begin
                    state_d = ST_OVER;
                end else begin
                    err_s   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shifter, and registered outputs. Reset wins over a bit on the
    // same edge and drops any partial burst silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cnt_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            frame_valid_q <= load_s;
            frame_err_q   <= err_s;
            busy_q        <= (state_d != ST_IDLE);
            if (load_s) begin
                frame_data_q <= shreg_q;
                frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
            end else begin
                frame_data_q <= frame_data_q;
                frame_cnt_q  <= frame_cnt_q;
            end
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign frame_cnt   = frame_cnt_q;
    assign busy        = busy_q;

`ifdef SEG_SERIAL_RX_DECODE_EN
    logic [FRAME_W/2-1:0] dec_hex_s;
    logic [FRAME_W/8-1:0] dec_ok_s;
    logic [FRAME_W/2-1:0] digit_hex_q;
    logic [FRAME_W/8-1:0] digit_ok_q;

    // Decode the shifter contents so that the digits load on the same edge
    // as frame_data.
    for (genvar g = 0; g < FRAME_W/8; g++) begin : g_dec
        seg_pattern_decode u_dec (
            .seg_byte_i (shreg_q[8*g +: 8]),
            .nibble_o   (dec_hex_s[4*g +: 4]),
            .ok_o       (dec_ok_s[g])
        );
    end

    // Decoded digit registers. They load together with frame_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_hex_q <= '0;
            digit_ok_q  <= '0;
        end else if (load_s) begin
            digit_hex_q <= dec_hex_s;
            digit_ok_q  <= dec_ok_s;
        end else begin
            digit_hex_q <= digit_hex_q;
            digit_ok_q  <= digit_ok_q;
        end
    end

    assign digit_hex = digit_hex_q;
    assign digit_ok  = digit_ok_q;
`endif

endmodule : seg_serial_rx

// File: doc/seg_serial_rx.md
Name: seg_serial_rx

Overview:
- Receive end of the serial seven-segment link produced by the segment shift driver.
- Deserialises the data line into a parallel frame using the driver's active-low `finish` as the bit strobe.
- Checks frame length and presents each completed frame with a one-cycle valid pulse.
- Used as a loopback checker on the board and as the scoreboard front end in simulation of the display path.

Parameters:
- FRAME_W, 64, bits per frame (segment driver word width)
- CNT_W, 8, width of the wrapping good-frame counter

Ports:
- clk  input  1  system clock; the same clock that drives the segment driver
- rst  input  1  synchronous, active-high reset
- seg_dt  input  1  serial data, MSB of frame first
- seg_finish  input  1  driver finish; 0 = a bit is present on seg_dt this cycle, 1 = idle
- frame_data  output  FRAME_W  last good frame, bit FRAME_W-1 = first bit received
- frame_valid  output  1  one-cycle pulse: frame_data just updated
- frame_err  output  1  one-cycle pulse: short or over-length burst discarded
- frame_cnt  output  CNT_W  count of good frames, wraps modulo 2^CNT_W
- busy  output  1  high while a burst is in progress (SHIFT or OVER)

Behaviour:
- All outputs 0 after reset.
- Reset is sampled on clk; it wins over any simultaneous bit, and a partial burst is dropped with no error.
- The shift register (shreg) and bit counter (bitcnt) are internal. bitcnt is $clog2(FRAME_W+1) bits wide.
- States:
  - IDLE: seg_finish=1 → stay. seg_finish=0 → shreg <= {shreg, seg_dt}, bitcnt <= 1, go to SHIFT.
  - SHIFT, seg_finish=0 and bitcnt < FRAME_W → shift in seg_dt, bitcnt++.
  - SHIFT, seg_finish=0 and bitcnt == FRAME_W → go to OVER; shreg is not modified.
  - SHIFT, seg_finish=1 and bitcnt == FRAME_W → frame_data <= shreg, frame_valid=1 next cycle, frame_cnt++, go to IDLE.
  - SHIFT, seg_finish=1 and bitcnt < FRAME_W → frame_err=1 next cycle, frame_data unchanged, go to IDLE.
  - OVER: seg_finish=0 → stay. seg_finish=1 → frame_err=1 next cycle, go to IDLE.
- Latency: frame_valid or frame_err is registered high in the cycle after the edge at which seg_finish=1 is first sampled. It stays high for exactly one cycle.
- Back-to-back frames: a single idle cycle between bursts is sufficient. A new burst may begin in the same cycle the previous valid or err pulse is high; that first bit is captured.
- frame_data holds its value until the next good frame. frame_valid and frame_err are never high together.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Optional Feature:
- Macro: SEG_SERIAL_RX_DECODE_EN
- With the macro defined:
  - Extra outputs `digit_hex` (4*FRAME_W/8 bits) and `digit_ok` (FRAME_W/8 bits) are added.
  - Each byte of frame_data (byte 0 = bits 7:0) is reverse-decoded from the segment pattern table to a hex nibble.
  - An unknown pattern gives nibble 0 and digit_ok bit 0.
  - Both outputs are registered together with frame_data and update in the same cycle as the frame_valid pulse. Reset value 0.
- Without the macro: these ports and this logic do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding (ST_IDLE, ST_SHIFT, ST_OVER)
  - the 16-entry segment pattern constants for hex 0-F, active-low, shared with the segment driver's encoder
  - FRAME_W default
- Natural sub-module: seg_pattern_decode. Combinational, one byte in, nibble and ok out. Instantiated FRAME_W/8 times under the macro.

Test Plan:
- Reset: hold rst 3 cycles with seg_finish=0 and toggling seg_dt → all outputs 0, busy 0 after release.
- Good frame: drive 64'hA5A5_0000_FFFF_1234 MSB-first with seg_finish=0 for 64 cycles, then 1 → frame_valid is high exactly 1 cycle after seg_finish rises, frame_data = 64'hA5A5_0000_FFFF_1234, frame_cnt = 1.
- Short frame: 10 bits then idle → frame_err 1-cycle pulse, no frame_valid, frame_data and frame_cnt unchanged.
- Over-length: 70 bits → busy stays high through bit 70, then frame_err pulse, no frame_valid, frame_cnt unchanged.
- Mid-frame reset: assert rst at bit 30, then send a full frame of 64'h0123_4567_89AB_CDEF → exactly one frame_valid, data matches, no frame_err.
- Back-to-back with wrap:
  - Preload by sending 255 good frames, then two frames separated by 1 idle cycle → two frame_valid pulses 65 cycles apart, frame_cnt 255→0→1.
  - With SEG_SERIAL_RX_DECODE_EN: an all-"8" pattern frame → digit_hex = 32'h8888_8888, digit_ok = 8'hFF.
